// File: rtl/softmax_pkg_16.sv
// -----------------------------------------------------------------------------
// softmax_pkg_16
// Shared constants for the softmax result path:
//   DATA_SIZE / NUMBER_OF_DATA / FIFO_DEPTH : default geometry
//   ST_IDLE / ST_COLLECT / ST_DRAIN         : collector state encodings
//   cnt_width() / ptr_width()               : clog2-based width helpers
// -----------------------------------------------------------------------------
package softmax_pkg_16;

    localparam int DATA_SIZE      = 16;
    localparam int NUMBER_OF_DATA = 10;
    localparam int FIFO_DEPTH     = 4;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;

    // Element counter must be able to hold the value n itself.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // FIFO pointer width: address bits plus one wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_16.sv
// -----------------------------------------------------------------------------
// sync_fifo_16
// Small single-clock FIFO holding paired result words plus their last bit
// (the MSB of each entry).
//   clock_i      in   clock, rising edge
//   reset_n_i    in   asynchronous active-low reset (empties the FIFO)
//   push_i       in   write push_data_i (ignored when full unless popping)
//   push_data_i  in   entry to write
//   pop_i        in   remove head entry (ignored when empty)
//   mark_last_i  in   set the MSB of the most recently written entry
//   head_o       out  head entry (combinational from the storage array)
//   full_o       out  FIFO full
//   empty_o      out  FIFO empty
//   count_o      out  number of stored entries
// -----------------------------------------------------------------------------
module sync_fifo_16 #(
    parameter int width = 33,
    parameter int depth = 4
) (
    input  logic                       clock_i,
    input  logic                       reset_n_i,
    input  logic                       push_i,
    input  logic [width-1:0]           push_data_i,
    input  logic                       pop_i,
    input  logic                       mark_last_i,
    output logic [width-1:0]           head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(depth):0]     count_o
);

    localparam int AW = $clog2(depth);

    logic [width-1:0] mem_q [depth];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    tail_idx;
    logic             do_push;
    logic             do_pop;

    // Wrap bit distinguishes full from empty when the address bits match.
    assign empty_o  = (wr_ptr_q == rd_ptr_q);
    assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o  = wr_ptr_q - rd_ptr_q;
    assign head_o   = mem_q[rd_ptr_q[AW-1:0]];
    assign tail_idx = wr_ptr_q[AW-1:0] - AW'(1);

    // A push into a full FIFO is still accepted when the head leaves the
    // same cycle; a pop from an empty FIFO is never valid.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge clock_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end else if (mark_last_i && !empty_o) begin
            mem_q[tail_idx][width-1] <= 1'b1;
        end
    end

endmodule

// File: rtl/result_collector_16.sv
// -----------------------------------------------------------------------------
// result_collector_16
// Collects the single-element result stream of the softmax exp stage, packs
// consecutive elements into 2*data_size words ({later, earlier}) and hands
// them to the host through a small FIFO with a valid/ready interface.
//   clock_i               in   clock, rising edge
//   reset_n_i             in   asynchronous active-low reset
//   collect_data_i        in   result element
//   collect_data_valid_i  in   element valid (no backpressure upstream)
//   collect_done_i        in   upstream finished the vector
//   collect_ready_i       in   host accepts collect_data_o
//   collect_data_o        out  paired word, low half = earlier element
//   collect_data_valid_o  out  paired word valid (FIFO not empty)
//   collect_last_o        out  final word of the vector
//   collect_busy_o        out  collector not idle
//   collect_short_o       out  sticky: vector ended early
//   collect_overflow_o    out  sticky: element or word dropped
// -----------------------------------------------------------------------------
module result_collector_16
    import softmax_pkg_16::*;
#(
    parameter int data_size      = DATA_SIZE,
    parameter int number_of_data = NUMBER_OF_DATA,
    parameter int fifo_depth     = FIFO_DEPTH
) (
    input  logic                     clock_i,
    input  logic                     reset_n_i,
    input  logic [data_size-1:0]     collect_data_i,
    input  logic                     collect_data_valid_i,
    input  logic                     collect_done_i,
    input  logic                     collect_ready_i,
    output logic [2*data_size-1:0]   collect_data_o,
    output logic                     collect_data_valid_o,
    output logic                     collect_last_o,
    output logic                     collect_busy_o,
    output logic                     collect_short_o,
    output logic                     collect_overflow_o
);

    localparam int CW = cnt_width(number_of_data);
    localparam int WW = 2 * data_size;
    localparam int EW = WW + 1;
    localparam int PW = ptr_width(fifo_depth);
    localparam logic [CW-1:0] N_LAST = CW'(number_of_data);

    logic [1:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [data_size-1:0] half_q, half_d;
    logic                 half_valid_q, half_valid_d;
    logic                 short_q, short_d;
    logic                 overflow_q, overflow_d;

    logic                 accept;
    logic                 in_vector;
    logic                 close;
    logic [CW-1:0]        cnt_next;

    logic                 fifo_push;
    logic [EW-1:0]        fifo_push_data;
    logic                 fifo_pop;
    logic                 fifo_mark_last;
    logic [EW-1:0]        fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [PW-1:0]        fifo_count;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        half_d         = half_q;
        half_valid_d   = half_valid_q;
        short_d        = short_q;
        overflow_d     = overflow_q;
        fifo_push      = 1'b0;
        fifo_push_data = '0;
        fifo_mark_last = 1'b0;

        fifo_pop  = !fifo_empty && collect_ready_i;
        accept    = collect_data_valid_i &&
                    (state_q == ST_IDLE || state_q == ST_COLLECT);
        // A vector is open in COLLECT, or in IDLE when its first element
        // arrives (so done on the very first element still closes it).
        in_vector = (state_q == ST_COLLECT) || accept;
        cnt_next  = cnt_q + CW'(accept);
        close     = in_vector && ((accept && cnt_next == N_LAST) || collect_done_i);

        if (accept && state_q == ST_IDLE) begin
            state_d    = ST_COLLECT;
            short_d    = 1'b0;
            overflow_d = 1'b0;
        end

        if (state_q == ST_DRAIN && collect_data_valid_i) begin
            overflow_d = 1'b1;
        end

        // Even index parks in the half register, odd index completes a pair.
        if (accept) begin
            cnt_d = cnt_next;
            if (!cnt_q[0]) begin
                half_d       = collect_data_i;
                half_valid_d = 1'b1;
            end else begin
                fifo_push      = 1'b1;
                fifo_push_data = {1'b0, collect_data_i, half_q};
                half_valid_d   = 1'b0;
            end
        end

        if (close) begin
            state_d      = ST_DRAIN;
            cnt_d        = '0;
            half_valid_d = 1'b0;
            if (accept && cnt_q[0]) begin
                fifo_push_data[WW] = 1'b1;
            end else if (accept) begin
                fifo_push      = 1'b1;
                fifo_push_data = {1'b1, {data_size{1'b0}}, collect_data_i};
            end else if (half_valid_q) begin
                fifo_push      = 1'b1;
                fifo_push_data = {1'b1, {data_size{1'b0}}, half_q};
            end else if (fifo_count > PW'(1) || (fifo_count == PW'(1) && !fifo_pop)) begin
                // Newest word is still queued and not leaving now: tag it.
                fifo_mark_last = 1'b1;
            end else begin
                // Newest word already gone (or leaving now): emit an empty
                // terminator so the host still sees last.
                fifo_push      = 1'b1;
                fifo_push_data = {1'b1, {WW{1'b0}}};
            end
            if (collect_done_i && cnt_next < N_LAST) begin
                short_d = 1'b1;
            end
        end

        // Dropped push. If it carried last, move last onto the queued tail
        // so the vector still terminates and DRAIN can exit.
        if (fifo_push && fifo_full && !fifo_pop) begin
            overflow_d = 1'b1;
            if (close) begin
                fifo_mark_last = 1'b1;
            end
        end

        if (state_q == ST_DRAIN && fifo_pop && fifo_head[WW]) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            half_q       <= '0;
            half_valid_q <= 1'b0;
            short_q      <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            half_q       <= half_d;
            half_valid_q <= half_valid_d;
            short_q      <= short_d;
            overflow_q   <= overflow_d;
        end
    end

    sync_fifo_16 #(
        .width (EW),
        .depth (fifo_depth)
    ) u_fifo (
        .clock_i     (clock_i),
        .reset_n_i   (reset_n_i),
        .push_i      (fifo_push),
        .push_data_i (fifo_push_data),
        .pop_i       (fifo_pop),
        .mark_last_i (fifo_mark_last),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Mask the head while empty so the outputs read zero after reset.
    assign collect_data_valid_o = !fifo_empty;
    assign collect_data_o       = fifo_empty ? '0 : fifo_head[WW-1:0];
    assign collect_last_o       = !fifo_empty && fifo_head[WW];
    assign collect_busy_o       = (state_q != ST_IDLE);
    assign collect_short_o      = short_q;
    assign collect_overflow_o   = overflow_q;

endmodule

// File: tb/tb_result_collector_16.sv
module tb_result_collector_16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] din;
    logic        din_v;
    logic        done;
    logic        rdy;

    logic [31:0] d10, d5;
    logic        v10, v5, l10, l5, b10, b5, s10, s5, o10, o5;

    int n_checks = 0;
    int n_errors = 0;

    logic [32:0] got10 [$];
    logic [32:0] got5  [$];

    always #5 clk = ~clk;

    result_collector_16 #(.data_size(16), .number_of_data(10), .fifo_depth(4)) dut (
        .clock_i              (clk),
        .reset_n_i            (rst_n),
        .collect_data_i       (din),
        .collect_data_valid_i (din_v),
        .collect_done_i       (done),
        .collect_ready_i      (rdy),
        .collect_data_o       (d10),
        .collect_data_valid_o (v10),
        .collect_last_o       (l10),
        .collect_busy_o       (b10),
        .collect_short_o      (s10),
        .collect_overflow_o   (o10)
    );

    result_collector_16 #(.data_size(16), .number_of_data(5), .fifo_depth(4)) dut5 (
        .clock_i              (clk),
        .reset_n_i            (rst_n),
        .collect_data_i       (din),
        .collect_data_valid_i (din_v),
        .collect_done_i       (done),
        .collect_ready_i      (rdy),
        .collect_data_o       (d5),
        .collect_data_valid_o (v5),
        .collect_last_o       (l5),
        .collect_busy_o       (b5),
        .collect_short_o      (s5),
        .collect_overflow_o   (o5)
    );

    // Inputs only change just after a rising edge, so the negedge view of
    // valid & ready is exactly what the next rising edge will transfer.
    always @(negedge clk) begin
        if (rst_n && v10 && rdy) begin
            got10.push_back({l10, d10});
            $display("n10 word: data=%08h last=%0b", d10, l10);
        end
        if (rst_n && v5 && rdy) begin
            got5.push_back({l5, d5});
            $display("n5  word: data=%08h last=%0b", d5, l5);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [15:0] v, input logic d);
        din   = v;
        din_v = 1'b1;
        done  = d;
        tick(1);
        din_v = 1'b0;
        done  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        din   = '0;
        din_v = 1'b0;
        done  = 1'b0;
        tick(2);
        check("rst_valid",    {63'd0, v10}, 64'd0);
        check("rst_data",     {32'd0, d10}, 64'd0);
        check("rst_busy",     {63'd0, b10}, 64'd0);
        check("rst_flags",    {62'd0, s10, o10}, 64'd0);
        rst_n = 1'b1;
        got10.delete();
        got5.delete();
    endtask

    function automatic logic [32:0] word10(input int i);
        return (i < got10.size()) ? got10[i] : '1;
    endfunction

    function automatic logic [32:0] word5(input int i);
        return (i < got5.size()) ? got5[i] : '1;
    endfunction

    logic [32:0] t1_exp [5];
    logic [32:0] t2_exp [3];

    initial begin
        t1_exp = '{33'h0_0002_0001, 33'h0_0004_0003, 33'h0_0006_0005,
                   33'h0_0008_0007, 33'h1_000A_0009};
        t2_exp = '{33'h0_0012_0011, 33'h0_0014_0013, 33'h1_0000_0015};
        rdy = 1'b1;

        // T1: full vector, back-to-back, host always ready
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            send(16'(i), 1'b0);
            if (i == 2) begin
                check("t1_lat_valid", {63'd0, v10}, 64'd1);
                check("t1_lat_data",  {32'd0, d10}, 64'h0002_0001);
            end
        end
        tick(5);
        check("t1_count", 64'(got10.size()), 64'd5);
        for (int i = 0; i < 5; i++) check($sformatf("t1_word%0d", i), {31'd0, word10(i)}, {31'd0, t1_exp[i]});
        check("t1_flags", {62'd0, s10, o10}, 64'd0);
        check("t1_busy",  {63'd0, b10}, 64'd0);

        // T2: odd vector length, final word zero-padded
        do_reset();
        for (int i = 0; i < 5; i++) send(16'h11 + 16'(i), 1'b0);
        tick(5);
        check("t2_count", 64'(got5.size()), 64'd3);
        for (int i = 0; i < 3; i++) check($sformatf("t2_word%0d", i), {31'd0, word5(i)}, {31'd0, t2_exp[i]});
        check("t2_busy",  {63'd0, b5}, 64'd0);
        check("t2_short", {63'd0, s5}, 64'd0);

        // T3: host stalled, FIFO fills, fifth word dropped
        do_reset();
        rdy = 1'b0;
        for (int i = 1; i <= 8; i++) send(16'(i), 1'b0);
        check("t3_ovf_before", {63'd0, o10}, 64'd0);
        send(16'd9, 1'b0);
        send(16'd10, 1'b0);
        check("t3_ovf_after", {63'd0, o10}, 64'd1);
        check("t3_head_valid", {63'd0, v10}, 64'd1);
        check("t3_head_data",  {32'd0, d10}, 64'h0002_0001);
        tick(3);
        check("t3_stable_data", {32'd0, d10}, 64'h0002_0001);
        check("t3_stable_last", {63'd0, l10}, 64'd0);
        rdy = 1'b1;
        tick(8);
        check("t3_count", 64'(got10.size()), 64'd4);
        for (int i = 0; i < 4; i++) check($sformatf("t3_word%0d", i), {32'd0, word10(i)[31:0]}, {32'd0, t1_exp[i][31:0]});

        // T4: early done with a pending half element
        do_reset();
        send(16'd7, 1'b0);
        send(16'd8, 1'b0);
        send(16'd9, 1'b0);
        done = 1'b1;
        tick(1);
        done = 1'b0;
        tick(5);
        check("t4_count", 64'(got10.size()), 64'd2);
        check("t4_word0", {31'd0, word10(0)}, 64'h0_0008_0007);
        check("t4_word1", {31'd0, word10(1)}, 64'h1_0000_0009);
        check("t4_short", {63'd0, s10}, 64'd1);
        check("t4_ovf",   {63'd0, o10}, 64'd0);
        check("t4_busy",  {63'd0, b10}, 64'd0);

        // T5: asynchronous reset with words queued, then a clean vector
        do_reset();
        rdy = 1'b0;
        for (int i = 1; i <= 4; i++) send(16'(i), 1'b0);
        done = 1'b1;
        tick(1);
        done = 1'b0;
        check("t5_pre_busy",  {63'd0, b10}, 64'd1);
        check("t5_pre_short", {63'd0, s10}, 64'd1);
        check("t5_pre_valid", {63'd0, v10}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_valid", {63'd0, v10}, 64'd0);
        check("t5_async_busy",  {63'd0, b10}, 64'd0);
        check("t5_async_flags", {62'd0, s10, o10}, 64'd0);
        check("t5_async_data",  {32'd0, d10}, 64'd0);
        tick(1);
        rst_n = 1'b1;
        rdy   = 1'b1;
        got10.delete();
        got5.delete();
        for (int i = 1; i <= 10; i++) send(16'(i), 1'b0);
        tick(5);
        check("t5_count", 64'(got10.size()), 64'd5);
        for (int i = 0; i < 5; i++) check($sformatf("t5_word%0d", i), {31'd0, word10(i)}, {31'd0, t1_exp[i]});

        // T6: done together with the tenth element, then an element in DRAIN
        do_reset();
        for (int i = 1; i <= 9; i++) send(16'(i), 1'b0);
        send(16'd10, 1'b1);
        send(16'h77, 1'b0);
        tick(5);
        check("t6_count", 64'(got10.size()), 64'd5);
        for (int i = 0; i < 5; i++) check($sformatf("t6_word%0d", i), {31'd0, word10(i)}, {31'd0, t1_exp[i]});
        check("t6_ovf",   {63'd0, o10}, 64'd1);
        check("t6_short", {63'd0, s10}, 64'd0);
        check("t6_busy",  {63'd0, b10}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
